// File: rtl/mc_ctrl_unit_if.sv
// rtl/mc_ctrl_unit_if.sv - control/datapath signal bundle for the multi-cycle controller
interface mc_ctrl_unit_if;
    // Inputs to the controller, coming from the datapath and memory
    logic [3:0] opcode;
    logic       FLAGzero;
    logic       mem_ready;

    // Controls from the controller to the datapath and memory
    logic [3:0] MODE;
    logic       ALUsrcA;
    logic [1:0] ALUsrcB;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRwrite;
    logic       PCwrite;
    logic [1:0] PCsrc;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       halted;

    // Controller side
    modport master (
        input  opcode, FLAGzero, mem_ready,
        output MODE, ALUsrcA, ALUsrcB, IorD, MemRead, MemWrite, IRwrite,
               PCwrite, PCsrc, RegWrite, RegDst, MemtoReg, halted
    );

    // Datapath/memory side
    modport slave (
        output opcode, FLAGzero, mem_ready,
        input  MODE, ALUsrcA, ALUsrcB, IorD, MemRead, MemWrite, IRwrite,
               PCwrite, PCsrc, RegWrite, RegDst, MemtoReg, halted
    );
endinterface

// File: rtl/mc_ctrl_unit.sv
// rtl/mc_ctrl_unit.sv - multi-cycle control FSM for the 16-bit MIPS-style core
module mc_ctrl_unit #(
    parameter int unsigned PC_INC  = 1,
    parameter logic [3:0]  HALT_OP = 4'b1111
) (
    input  logic           clk,
    input  logic           rst,
    mc_ctrl_unit_if.master bus
);

    // The datapath adds PC_INC on ALUsrcB=01; a zero step would freeze the PC.
    if (PC_INC == 0) begin : g_pc_inc_check
        $error("mc_ctrl_unit: PC_INC must be non-zero");
    end

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR,
        MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b1000;
    localparam logic [3:0] OP_LW   = 4'b1001;
    localparam logic [3:0] OP_SW   = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BNE  = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_J    = 4'b1110;

    localparam logic [3:0] MODE_ADD = 4'b0001;
    localparam logic [3:0] MODE_SUB = 4'b0010;
    localparam logic [3:0] MODE_SLT = 4'b1111;

    typedef struct packed {
        logic [3:0] mode;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       halted;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;

    // State register; reset abandons any instruction in flight and restarts at FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; opcode is IR[15:12], stable after FETCH
    always_comb begin
        state_nxt = state;
        ctrl      = '0;
        case (state)
            FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = 2'b01;
                ctrl.mode    = MODE_ADD;
                ctrl.irwrite = bus.mem_ready;
                ctrl.pcwrite = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                // Precompute the branch target into ALUOut
                ctrl.alusrcb = 2'b10;
                ctrl.mode    = MODE_ADD;
                if (bus.opcode == HALT_OP) begin
                    state_nxt = HALT;
                end else begin
                    case (bus.opcode)
                        OP_NOP:                     state_nxt = FETCH;
                        4'b0001, 4'b0010, 4'b0011,
                        4'b0100, 4'b0101, 4'b0110,
                        4'b0111, OP_SLT:            state_nxt = EXEC_R;
                        OP_ADDI:                    state_nxt = EXEC_I;
                        OP_LW, OP_SW:               state_nxt = MEM_ADDR;
                        OP_BEQ, OP_BNE:             state_nxt = BRANCH;
                        OP_J:                       state_nxt = JUMP;
                        default:                    state_nxt = FETCH;
                    endcase
                end
            end
            EXEC_R: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b00;
                ctrl.mode    = (bus.opcode == OP_SLT) ? MODE_SLT : bus.opcode;
                state_nxt    = ALU_WB;
            end
            EXEC_I: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.mode    = MODE_ADD;
                state_nxt    = ALU_WB;
            end
            ALU_WB: begin
                ctrl.regwrite = 1'b1;
                state_nxt     = FETCH;
            end
            MEM_ADDR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.mode    = MODE_ADD;
                state_nxt    = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt = MEM_WB;
                end
            end
            MEM_WB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                state_nxt     = FETCH;
            end
            MEM_WR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt = FETCH;
                end
            end
            BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b00;
                ctrl.mode    = MODE_SUB;
                ctrl.pcsrc   = 2'b01;
                ctrl.pcwrite = (bus.opcode == OP_BNE) ? ~bus.FLAGzero : bus.FLAGzero;
                state_nxt    = FETCH;
            end
            JUMP: begin
                ctrl.pcsrc   = 2'b10;
                ctrl.pcwrite = 1'b1;
                state_nxt    = FETCH;
            end
            HALT: begin
                ctrl.halted = 1'b1;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Reset forces every control low immediately, without waiting for a clock edge
    assign {bus.MODE, bus.ALUsrcA, bus.ALUsrcB, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRwrite, bus.PCwrite, bus.PCsrc, bus.RegWrite, bus.RegDst,
            bus.MemtoReg, bus.halted} = rst ? '0 : ctrl;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb/tb_mc_ctrl_unit.sv - scoreboard testbench for mc_ctrl_unit
module tb_mc_ctrl_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mc_ctrl_unit_if bus();

    mc_ctrl_unit #(
        .PC_INC (1),
        .HALT_OP(4'b1111)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [3:0] mode;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       halted;
    } out_t;

    typedef enum int {
        S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } st_e;

    out_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Expected controls for a state, straight from the controller's output table
    function automatic out_t exp_out(st_e s, logic [3:0] op, logic fz, logic rdy);
        out_t e = '0;
        case (s)
            S_FETCH:    begin e.memread = 1; e.alusrcb = 2'b01; e.mode = 4'b0001;
                              e.irwrite = rdy; e.pcwrite = rdy; end
            S_DECODE:   begin e.alusrcb = 2'b10; e.mode = 4'b0001; end
            S_EXEC_R:   begin e.alusrca = 1; e.alusrcb = 2'b00;
                              e.mode = (op == 4'b1101) ? 4'b1111 : op; end
            S_EXEC_I,
            S_MEM_ADDR: begin e.alusrca = 1; e.alusrcb = 2'b10; e.mode = 4'b0001; end
            S_ALU_WB:   begin e.regwrite = 1; end
            S_MEM_RD:   begin e.memread = 1; e.iord = 1; end
            S_MEM_WB:   begin e.regwrite = 1; e.memtoreg = 1; end
            S_MEM_WR:   begin e.memwrite = 1; e.iord = 1; end
            S_BRANCH:   begin e.alusrca = 1; e.alusrcb = 2'b00; e.mode = 4'b0010;
                              e.pcsrc = 2'b01; e.pcwrite = (op == 4'b1100) ? ~fz : fz; end
            S_JUMP:     begin e.pcsrc = 2'b10; e.pcwrite = 1; end
            S_HALT:     begin e.halted = 1; end
            default:    e = '0;
        endcase
        return e;
    endfunction

    function automatic out_t observe();
        out_t o;
        o.mode     = bus.MODE;
        o.alusrca  = bus.ALUsrcA;
        o.alusrcb  = bus.ALUsrcB;
        o.iord     = bus.IorD;
        o.memread  = bus.MemRead;
        o.memwrite = bus.MemWrite;
        o.irwrite  = bus.IRwrite;
        o.pcwrite  = bus.PCwrite;
        o.pcsrc    = bus.PCsrc;
        o.regwrite = bus.RegWrite;
        o.regdst   = bus.RegDst;
        o.memtoreg = bus.MemtoReg;
        o.halted   = bus.halted;
        return o;
    endfunction

    // Apply one cycle of inputs at the falling edge and queue what the DUT must show
    task automatic drive_cycle(input st_e s, input logic [3:0] op, input logic fz,
                               input logic rdy);
        @(negedge clk);
        bus.opcode    = op;
        bus.FLAGzero  = fz;
        bus.mem_ready = rdy;
        sb.push_back(exp_out(s, op, fz, rdy));
    endtask

    task automatic test_reset();
        out_t obs, exp;
        rst           = 1'b1;
        bus.opcode    = 4'b1001;
        bus.FLAGzero  = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sb.push_back(exp_out(S_RESET, 4'b1001, 1'b1, 1'b1));
        #1;
        obs = observe();
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", obs, exp);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.mem_ready = 1'b0;
        sb.push_back(exp_out(S_FETCH, 4'b1001, 1'b1, 1'b0));
        #1;
        obs = observe();
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_release_fetch got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0] ops [10];
        st_e        seq[$];
        out_t       obs, exp;
        ops = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                4'b0110, 4'b0111, 4'b1101, 4'b1000, 4'b0000};
        foreach (ops[k]) begin
            if (ops[k] == 4'b0000)
                seq = '{S_FETCH, S_DECODE, S_FETCH};
            else if (ops[k] == 4'b1000)
                seq = '{S_FETCH, S_DECODE, S_EXEC_I, S_ALU_WB, S_FETCH};
            else
                seq = '{S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB, S_FETCH};
            // mem_ready high outside FETCH must be ignored; last FETCH waits
            foreach (seq[i]) begin
                drive_cycle(seq[i], ops[k], 1'b0, (i != seq.size() - 1));
                #1;
                obs = observe();
                exp = sb.pop_front();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL alu op=%b cyc%0d got=%h want=%h", ops[k], i, obs, exp);
                end
            end
        end
    endtask

    task automatic test_lw_wait();
        st_e  seq[$];
        logic rdy[$];
        out_t obs, exp;
        seq = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_WB, S_FETCH};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        foreach (seq[i]) begin
            drive_cycle(seq[i], 4'b1001, 1'b0, rdy[i]);
            #1;
            obs = observe();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lw cyc%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_sw_wait();
        st_e  seq[$];
        logic rdy[$];
        out_t obs, exp;
        seq = '{S_FETCH, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR, S_MEM_WR, S_FETCH};
        rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        foreach (seq[i]) begin
            drive_cycle(seq[i], 4'b1010, 1'b0, rdy[i]);
            #1;
            obs = observe();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL sw cyc%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_branch();
        logic [3:0] ops [4];
        logic       fzs [4];
        st_e        seq[$];
        out_t       obs, exp;
        ops = '{4'b1011, 4'b1011, 4'b1100, 4'b1100};
        fzs = '{1'b1, 1'b0, 1'b1, 1'b0};
        seq = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        foreach (ops[k]) begin
            foreach (seq[i]) begin
                drive_cycle(seq[i], ops[k], fzs[k], (i != seq.size() - 1));
                #1;
                obs = observe();
                exp = sb.pop_front();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL branch op=%b fz=%b cyc%0d got=%h want=%h",
                             ops[k], fzs[k], i, obs, exp);
                end
            end
        end
    endtask

    task automatic test_jump();
        st_e  seq[$];
        out_t obs, exp;
        seq = '{S_FETCH, S_DECODE, S_JUMP, S_FETCH};
        foreach (seq[i]) begin
            drive_cycle(seq[i], 4'b1110, 1'b1, (i != seq.size() - 1));
            #1;
            obs = observe();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL jump cyc%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_halt();
        st_e  seq[$];
        out_t obs, exp;
        seq = '{S_FETCH, S_DECODE};
        for (int h = 0; h < 20; h++) seq.push_back(S_HALT);
        foreach (seq[i]) begin
            drive_cycle(seq[i], 4'b1111, i[1], (i < 2) ? 1'b1 : i[0]);
            #1;
            obs = observe();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL halt cyc%0d got=%h want=%h", i, obs, exp);
            end
        end
        #1;
        rst = 1'b1;
        sb.push_back(exp_out(S_RESET, 4'b1111, 1'b0, 1'b1));
        #1;
        obs = observe();
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL halt_reset got=%h want=%h", obs, exp);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.opcode    = 4'b0000;
        bus.mem_ready = 1'b1;
        sb.push_back(exp_out(S_FETCH, 4'b0000, 1'b0, 1'b1));
        #1;
        obs = observe();
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL halt_release_fetch got=%h want=%h", obs, exp);
        end
        seq = '{S_DECODE, S_FETCH};
        foreach (seq[i]) begin
            drive_cycle(seq[i], 4'b0000, 1'b0, 1'b0);
            #1;
            obs = observe();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL halt_after_nop cyc%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        st_e  seq[$];
        logic rdy[$];
        out_t obs, exp;
        seq = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
        foreach (seq[i]) begin
            drive_cycle(seq[i], 4'b1010, 1'b0, rdy[i]);
            #1;
            obs = observe();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midwr cyc%0d got=%h want=%h", i, obs, exp);
            end
        end
        // Still inside the MEM_WR cycle: no clock edge between here and the check
        #1;
        rst = 1'b1;
        sb.push_back(exp_out(S_RESET, 4'b1010, 1'b0, 1'b0));
        #1;
        obs = observe();
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL midwr_async_drop got=%h want=%h", obs, exp);
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        sb.push_back(exp_out(S_RESET, 4'b1010, 1'b0, 1'b1));
        #1;
        obs = observe();
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL midwr_reset_held got=%h want=%h", obs, exp);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.mem_ready = 1'b0;
        sb.push_back(exp_out(S_FETCH, 4'b1010, 1'b0, 1'b0));
        #1;
        obs = observe();
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL midwr_release_fetch got=%h want=%h", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_lw_wait();
        test_sw_wait();
        test_branch();
        test_jump();
        test_reset_mid_write();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
